// File: rtl/evolution_pkg.sv
// Shared constants and types for the Game-of-Life cell evaluator (package life_pkg).
package life_pkg;

  localparam int unsigned NBR_W = 9;
  localparam int unsigned CNT_W = 4;

  localparam logic [NBR_W-1:0] RULE_B3  = 9'b000001000;
  localparam logic [NBR_W-1:0] RULE_S23 = 9'b000001100;

  // Bit positions inside status: centre first, then clockwise from (i,j+1).
  localparam int unsigned IDX_C  = 0;
  localparam int unsigned IDX_E  = 1;
  localparam int unsigned IDX_SE = 2;
  localparam int unsigned IDX_S  = 3;
  localparam int unsigned IDX_SW = 4;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned IDX_NW = 6;
  localparam int unsigned IDX_N  = 7;
  localparam int unsigned IDX_NE = 8;

  typedef logic [NBR_W-1:0] nbr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    nbr_t birth;
    nbr_t survive;
  } rule_t;

endpackage

// File: rtl/evolution_if.sv
// Neighbourhood/result bundle between a sweep controller (master) and the evaluator (slave).
interface evolution_if;
  import life_pkg::*;

  nbr_t status;
  logic live;
  logic in_valid;
  logic out_valid;
  logic live_q;
  cnt_t count_q;

  modport master (
    output status, in_valid,
    input  live, out_valid, live_q, count_q
  );

  modport slave (
    input  status, in_valid,
    output live, out_valid, live_q, count_q
  );
endinterface

// File: rtl/evolution_popcount8.sv
// 8-input, 4-bit-result population count as a balanced adder tree.
module popcount8 (
  input  logic [7:0] bits_i,
  output logic [3:0] count_o
);
  logic [1:0] pair0, pair1, pair2, pair3;
  logic [2:0] quad0, quad1;

  always_comb begin
    pair0   = {1'b0, bits_i[0]} + {1'b0, bits_i[1]};
    pair1   = {1'b0, bits_i[2]} + {1'b0, bits_i[3]};
    pair2   = {1'b0, bits_i[4]} + {1'b0, bits_i[5]};
    pair3   = {1'b0, bits_i[6]} + {1'b0, bits_i[7]};
    quad0   = {1'b0, pair0} + {1'b0, pair1};
    quad1   = {1'b0, pair2} + {1'b0, pair3};
    count_o = {1'b0, quad0} + {1'b0, quad1};
  end
endmodule

// File: rtl/evolution.sv
// Single-cell Game-of-Life rule evaluator with a registered, valid-qualified result.
// Optional EVOLUTION_RUNTIME_RULE_EN adds rule_we/rule_birth/rule_survive for a writable rule.
module evolution
  import life_pkg::*;
#(
  parameter logic [8:0] BIRTH_MASK   = RULE_B3,
  parameter logic [8:0] SURVIVE_MASK = RULE_S23
) (
  input  logic        clk,
  input  logic        rst,
  evolution_if.slave  bus
`ifdef EVOLUTION_RUNTIME_RULE_EN
  ,
  input  logic        rule_we,
  input  logic [8:0]  rule_birth,
  input  logic [8:0]  rule_survive
`endif
);

  cnt_t  count;
  rule_t rule;
  logic  live_d;
  logic  live_q, out_valid_q;
  cnt_t  count_q;

  popcount8 u_popcount (
    .bits_i  (bus.status[IDX_NE:IDX_E]),
    .count_o (count)
  );

`ifdef EVOLUTION_RUNTIME_RULE_EN
  rule_t rule_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rule_q <= '{birth: BIRTH_MASK, survive: SURVIVE_MASK};
    end else if (rule_we) begin
      rule_q <= '{birth: rule_birth, survive: rule_survive};
    end
  end

  assign rule = rule_q;
`else
  assign rule = '{birth: BIRTH_MASK, survive: SURVIVE_MASK};
`endif

  always_comb begin
    live_d = bus.status[IDX_C] ? rule.survive[count] : rule.birth[count];
  end

  // The capture samples live_d, so a rule write on the same edge still uses the old rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      live_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        live_q  <= live_d;
        count_q <= count;
      end
    end
  end

  assign bus.live      = live_d;
  assign bus.out_valid = out_valid_q;
  assign bus.live_q    = live_q;
  assign bus.count_q   = count_q;

endmodule

// File: tb/tb_evolution.sv
// Self-checking bench for evolution: spec-level model plus directed literal vectors.
module tb_evolution;
  import life_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  evolution_if bus ();

`ifdef EVOLUTION_RUNTIME_RULE_EN
  logic       rule_we = 1'b0;
  logic [8:0] rule_birth = '0;
  logic [8:0] rule_survive = '0;
`endif

  evolution #(.BIRTH_MASK(9'b000001000), .SURVIVE_MASK(9'b000001100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef EVOLUTION_RUNTIME_RULE_EN
    ,
    .rule_we      (rule_we),
    .rule_birth   (rule_birth),
    .rule_survive (rule_survive)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ov_cnt = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: count neighbours, then apply "born with k" / "survives with k" rule sets.
  function automatic int nbr_count(input logic [8:0] s);
    int c = 0;
    for (int i = 1; i < 9; i++) if (s[i]) c++;
    return c;
  endfunction

  function automatic logic rule_live(input logic [8:0] s, input logic [8:0] born, input logic [8:0] stay);
    int c = nbr_count(s);
    return s[0] ? stay[c] : born[c];
  endfunction

  logic [8:0] m_birth = 9'b000001000;
  logic [8:0] m_surv  = 9'b000001100;
  logic       m_valid = 1'b0;
  logic       m_live_q = 1'b0;
  int         m_cnt_q = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid  = 1'b0;
      m_live_q = 1'b0;
      m_cnt_q  = 0;
      m_birth  = 9'b000001000;
      m_surv   = 9'b000001100;
    end else begin
      m_valid = bus.in_valid;
      if (bus.in_valid) begin
        m_live_q = rule_live(bus.status, m_birth, m_surv);
        m_cnt_q  = nbr_count(bus.status);
      end
`ifdef EVOLUTION_RUNTIME_RULE_EN
      if (rule_we) begin
        m_birth = rule_birth;
        m_surv  = rule_survive;
      end
`endif
    end
  end

  // Every negedge: combinational and registered outputs against the model.
  always @(negedge clk) begin
    check("live_model", int'(bus.live), int'(rule_live(bus.status, m_birth, m_surv)));
    check("out_valid_model", int'(bus.out_valid), int'(m_valid));
    check("live_q_model", int'(bus.live_q), int'(m_live_q));
    check("count_q_model", int'(bus.count_q), m_cnt_q);
    if (bus.out_valid === 1'b1) ov_cnt++;
  end

  // Drive at posedge+2, check live at +3; captured values checked at next posedge+1.
  task automatic vec(input string name, input logic [8:0] s, input logic exp_live, input int exp_cnt);
    @(posedge clk); #2;
    bus.status   = s;
    bus.in_valid = 1'b1;
    #1 check({name, "_live"}, int'(bus.live), int'(exp_live));
    @(posedge clk); #1;
    check({name, "_ov"}, int'(bus.out_valid), 1);
    check({name, "_live_q"}, int'(bus.live_q), int'(exp_live));
    check({name, "_count_q"}, int'(bus.count_q), exp_cnt);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.status   = '0;
    bus.in_valid = 1'b0;
    #12;
    check("reset_ov", int'(bus.out_valid), 0);
    check("reset_live_q", int'(bus.live_q), 0);
    check("reset_count_q", int'(bus.count_q), 0);
    rst = 1'b0;

    vec("zero",   9'h000,       1'b0, 0);
    vec("c_2",    9'b000000111, 1'b1, 2);
    vec("c_3",    9'b000001111, 1'b1, 3);
    vec("d_3",    9'b000001110, 1'b1, 3);
    vec("d_2",    9'b000000110, 1'b0, 2);
    vec("c_4",    9'b000011111, 1'b0, 4);
    vec("all",    9'h1FF,       1'b0, 8);
    vec("ring",   9'h1FE,       1'b0, 8);
    vec("d_3alt", 9'b101000100, 1'b1, 3);

    // Exhaustive sweep with in_valid held high.
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    ov_cnt = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      bus.status = 9'(i);
      @(posedge clk); #2;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    check("sweep_ov_cycles", ov_cnt, 512);

    // Async reset in mid-cycle while a capture is pending.
    @(posedge clk); #2;
    bus.status   = 9'b000001111;
    bus.in_valid = 1'b1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_ov", int'(bus.out_valid), 0);
    check("arst_live_q", int'(bus.live_q), 0);
    check("arst_count_q", int'(bus.count_q), 0);
    check("arst_live_tracks", int'(bus.live), 1);
    @(posedge clk); #1;
    check("arst_hold_ov", int'(bus.out_valid), 0);
    #1;
    rst = 1'b0;
    bus.status = 9'b000001110;
    @(posedge clk); #1;
    check("post_rst_ov", int'(bus.out_valid), 1);
    check("post_rst_live_q", int'(bus.live_q), 1);
    check("post_rst_count_q", int'(bus.count_q), 3);
    #1 bus.in_valid = 1'b0;

`ifdef EVOLUTION_RUNTIME_RULE_EN
    // B36/S23: a dead cell with six neighbours is born; reset restores B3/S23.
    @(posedge clk); #2;
    bus.status   = 9'b001111110;
    rule_we      = 1'b1;
    rule_birth   = 9'b001001000;
    rule_survive = 9'b000001100;
    bus.in_valid = 1'b1;
    #1 check("rule_before_write", int'(bus.live), 0);
    @(posedge clk); #1;
    check("rule_capture_old", int'(bus.live_q), 0);
    check("rule_new_live", int'(bus.live), 1);
    #1;
    rule_we = 1'b0;
    @(posedge clk); #1;
    check("rule_capture_new", int'(bus.live_q), 1);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1 check("rule_rst_live", int'(bus.live), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1 check("rule_after_rst_live", int'(bus.live), 0);
`endif

    @(posedge clk); #2;
    @(posedge clk); #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
